// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the control, program-load and instruction-output signals of the
// instruction fetch unit into one interface.
//   master : the CPU-side controller / program loader (drives control and
//            program-load inputs, observes the fetched instruction)
//   slave  : the fetch unit itself
// Signals:
//   run, stall, jump_en, jump_addr        fetch sequencing controls
//   prog_we, prog_addr, prog_data         program store write port
//   instruction, instr_valid, pc, halted  registered fetch results
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = $clog2(PROG_DEPTH),
  parameter int INSTR_W    = 6
);
  logic               run;
  logic               stall;
  logic               jump_en;
  logic [PC_W-1:0]    jump_addr;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               halted;

  modport master (
    output run, stall, jump_en, jump_addr, prog_we, prog_addr, prog_data,
    input  instruction, instr_valid, pc, halted
  );

  modport slave (
    input  run, stall, jump_en, jump_addr, prog_we, prog_addr, prog_data,
    output instruction, instr_valid, pc, halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Program counter, program store and fetch sequencer for the 6-bit
// accumulator CPU. One registered instruction per cycle goes to the decoder.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-high reset (pc, outputs, FSM; not the store)
//   bus  - instruction_fetch_unit_if.slave (controls, program load, outputs)
// Configuration macro:
//   IFU_WRAP_EN - when defined, the pc wraps from PROG_DEPTH-1 to 0 and
//                 fetching continues; HALT is then reached only through
//                 HALT_CODE. When undefined, issuing the last address halts.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                 PROG_DEPTH = 16,
  parameter int                 PC_W       = $clog2(PROG_DEPTH),
  parameter int                 INSTR_W    = 6,
  parameter logic [INSTR_W-1:0] NOP_CODE   = '0,
  parameter logic [INSTR_W-1:0] HALT_CODE  = '1
) (
  input logic                    clk,
  input logic                    rst,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

`ifndef IFU_WRAP_EN
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);
`endif

  state_t             state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               halted_q;
  logic [INSTR_W-1:0] mem [PROG_DEPTH];
  logic [INSTR_W-1:0] cur_word;

  assign cur_word        = mem[pc_q];
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;

  // Program store. It has no reset so a loaded program survives rst; writes
  // are only accepted while the sequencer is idle, and rst blocks them.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Fetch sequencer. Inside FETCH the branches are ordered by priority:
  // run dropping, then jump (which also beats stall and flushes one slot),
  // then stall, then halt-word detection, then a normal issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_CODE;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr_q <= NOP_CODE;
          valid_q <= 1'b0;
          if (bus.run) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          if (!bus.run) begin
            state   <= IDLE;
            instr_q <= NOP_CODE;
            valid_q <= 1'b0;
          end else if (bus.jump_en) begin
            pc_q    <= bus.jump_addr;
            instr_q <= NOP_CODE;
            valid_q <= 1'b0;
          end else if (bus.stall) begin
            // hold instruction, valid and pc
          end else if (cur_word == HALT_CODE) begin
            // pc stays on the halt word so it can be inspected
            state    <= HALT;
            instr_q  <= NOP_CODE;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            instr_q <= cur_word;
            valid_q <= 1'b1;
`ifdef IFU_WRAP_EN
            pc_q <= pc_q + PC_W'(1);
`else
            // The last word is still issued; the sequencer halts on the
            // same edge with pc parked on the last address.
            if (pc_q == LAST_PC) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_W'(1);
            end
`endif
          end
        end

        HALT: begin
          instr_q <= NOP_CODE;
          valid_q <= 1'b0;
          if (!bus.run) begin
            state    <= IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          instr_q <= NOP_CODE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit. A behavioural model of the
// fetch rules predicts instruction / instr_valid / pc / halted each cycle;
// directed scenarios from the datasheet examples are followed by a
// randomized phase. Honours IFU_WRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  localparam int PROG_DEPTH = 16;
  localparam int PC_W       = 4;
  localparam logic [5:0] NOP_W  = 6'h00;
  localparam logic [5:0] HALT_W = 6'h3F;
`ifdef IFU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.PROG_DEPTH(PROG_DEPTH)) bus ();

  instruction_fetch_unit #(.PROG_DEPTH(PROG_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: what the program store holds and what the decoder
  // should see after each clock edge.
  typedef enum {M_IDLE, M_FETCH, M_HALT} mode_t;
  mode_t      m_mode;
  logic [5:0] m_mem [PROG_DEPTH];
  int         m_pc;
  logic [5:0] m_instr;
  bit         m_valid;
  bit         m_halted;
  logic [5:0] prog [PROG_DEPTH];

  task automatic checkValue(input string name, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".instr"},  int'(bus.instruction), int'(m_instr));
    checkValue({tag, ".valid"},  int'(bus.instr_valid), int'(m_valid));
    checkValue({tag, ".pc"},     int'(bus.pc),          m_pc);
    checkValue({tag, ".halted"}, int'(bus.halted),      int'(m_halted));
  endtask

  // Directed expectation straight from the datasheet examples.
  task automatic expectOut(input string tag, input int instr, input int valid,
                           input int pc, input int halted);
    checkValue({tag, ".d_instr"},  int'(bus.instruction), instr);
    checkValue({tag, ".d_valid"},  int'(bus.instr_valid), valid);
    checkValue({tag, ".d_pc"},     int'(bus.pc),          pc);
    checkValue({tag, ".d_halted"}, int'(bus.halted),      halted);
  endtask

  task automatic modelStep(input int r, input int run, input int stall, input int jmp,
                           input int ja, input int we, input int pa, input int pd);
    if (r != 0) begin
      m_mode = M_IDLE; m_pc = 0; m_instr = NOP_W; m_valid = 0; m_halted = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (we != 0) m_mem[pa] = pd[5:0];
        m_instr = NOP_W; m_valid = 0;
        if (run != 0) m_mode = M_FETCH;
      end
      M_FETCH: begin
        if (run == 0) begin
          m_mode = M_IDLE; m_instr = NOP_W; m_valid = 0;
        end else if (jmp != 0) begin
          m_pc = ja; m_instr = NOP_W; m_valid = 0;
        end else if (stall != 0) begin
          m_valid = m_valid;
        end else if (m_mem[m_pc] == HALT_W) begin
          m_mode = M_HALT; m_instr = NOP_W; m_valid = 0; m_halted = 1;
        end else begin
          m_instr = m_mem[m_pc]; m_valid = 1;
          if (!WRAP && m_pc == PROG_DEPTH - 1) begin
            m_mode = M_HALT; m_halted = 1;
          end else begin
            m_pc = (m_pc + 1) % PROG_DEPTH;
          end
        end
      end
      default: begin
        m_instr = NOP_W; m_valid = 0;
        if (run == 0) begin
          m_mode = M_IDLE; m_pc = 0; m_halted = 0;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic applyStimulus(input string tag, input int r, input int run,
                               input int stall, input int jmp, input int ja,
                               input int we, input int pa, input int pd);
    rst           = r[0];
    bus.run       = run[0];
    bus.stall     = stall[0];
    bus.jump_en   = jmp[0];
    bus.jump_addr = ja[PC_W-1:0];
    bus.prog_we   = we[0];
    bus.prog_addr = pa[PC_W-1:0];
    bus.prog_data = pd[5:0];
    @(posedge clk);
    modelStep(r, run, stall, jmp, ja, we, pa, pd);
    #1;
    checkOutput(tag);
  endtask

  task automatic runCycle(input string tag);
    applyStimulus(tag, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadProgram();
    for (int i = 0; i < PROG_DEPTH; i++) begin
      applyStimulus("load", 0, 0, 0, 0, 0, 1, i, int'(prog[i]));
    end
  endtask

  initial begin
    $display("[TB] instruction_fetch_unit bench start (wrap=%0d)", WRAP);

    // Reset state
    applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 1, 1, 1, 1, 7, 1, 3, 9);
    expectOut("reset", 0, 0, 0, 0);

    // Scenario A: 05,09,0D then halt word at address 3
    prog[0] = 6'h05; prog[1] = 6'h09; prog[2] = 6'h0D; prog[3] = HALT_W;
    for (int i = 4; i < PROG_DEPTH; i++) prog[i] = 6'($urandom_range(0, 62));
    loadProgram();
    runCycle("A.enter"); expectOut("A.enter", 0, 0, 0, 0);
    runCycle("A.w0");    expectOut("A.w0", 'h05, 1, 1, 0);
    runCycle("A.w1");    expectOut("A.w1", 'h09, 1, 2, 0);
    runCycle("A.w2");    expectOut("A.w2", 'h0D, 1, 3, 0);
    runCycle("A.halt");  expectOut("A.halt", 0, 0, 3, 1);
    runCycle("A.hold");  expectOut("A.hold", 0, 0, 3, 1);
    applyStimulus("A.stop", 0, 0, 0, 0, 0, 0, 0, 0);
    expectOut("A.stop", 0, 0, 0, 0);

    // Scenario B: stall for 3 cycles while 0x09 is presented
    runCycle("B.enter"); runCycle("B.w0");
    runCycle("B.w1");    expectOut("B.w1", 'h09, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("B.stall", 0, 1, 1, 0, 0, 0, 0, 0);
      expectOut("B.stall", 'h09, 1, 2, 0);
    end
    runCycle("B.w2");    expectOut("B.w2", 'h0D, 1, 3, 0);
    runCycle("B.halt");  expectOut("B.halt", 0, 0, 3, 1);
    applyStimulus("B.stop", 0, 0, 0, 0, 0, 0, 0, 0);

    // Scenario C: jump to 2 while stalled flushes one slot
    runCycle("C.enter");
    runCycle("C.w0");    expectOut("C.w0", 'h05, 1, 1, 0);
    applyStimulus("C.jump", 0, 1, 1, 1, 2, 0, 0, 0);
    expectOut("C.jump", 0, 0, 2, 0);
    runCycle("C.w2");    expectOut("C.w2", 'h0D, 1, 3, 0);
    runCycle("C.halt");  expectOut("C.halt", 0, 0, 3, 1);
    applyStimulus("C.stop", 0, 0, 0, 0, 0, 0, 0, 0);

    // Scenario D: program without a halt word
    for (int i = 0; i < PROG_DEPTH; i++) prog[i] = 6'($urandom_range(0, 62));
    loadProgram();
    runCycle("D.enter");
    for (int i = 0; i < PROG_DEPTH - 1; i++) begin
      runCycle("D.w");
      expectOut("D.w", int'(prog[i]), 1, i + 1, 0);
    end
    runCycle("D.last");
    if (WRAP) expectOut("D.last", int'(prog[PROG_DEPTH-1]), 1, 0, 0);
    else      expectOut("D.last", int'(prog[PROG_DEPTH-1]), 1, PROG_DEPTH - 1, 1);
    runCycle("D.after");
    if (WRAP) expectOut("D.after", int'(prog[0]), 1, 1, 0);
    else      expectOut("D.after", 0, 0, PROG_DEPTH - 1, 1);
    applyStimulus("D.rst", 1, 0, 0, 0, 0, 0, 0, 0);

    // Scenario E: prog_we during FETCH ignored, rst mid-fetch at pc=5
    runCycle("E.enter");
    for (int i = 0; i < 4; i++) runCycle("E.w");
    applyStimulus("E.we", 0, 1, 0, 0, 0, 1, 0, int'(HALT_W));
    expectOut("E.we", int'(prog[4]), 1, 5, 0);
    applyStimulus("E.rst", 1, 1, 0, 0, 0, 0, 0, 0);
    expectOut("E.rst", 0, 0, 0, 0);
    runCycle("E.enter2");
    runCycle("E.w0");    expectOut("E.w0", int'(prog[0]), 1, 1, 0);

    // Randomized phase
    for (int n = 0; n < 800; n++) begin
      int r, run, stall, jmp, ja, we, pa, pd;
      r     = ($urandom_range(0, 49) == 0) ? 1 : 0;
      run   = ($urandom_range(0, 9) != 0) ? 1 : 0;
      stall = ($urandom_range(0, 4) == 0) ? 1 : 0;
      jmp   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      ja    = int'($urandom_range(0, PROG_DEPTH - 1));
      we    = int'($urandom_range(0, 1));
      pa    = int'($urandom_range(0, PROG_DEPTH - 1));
      pd    = ($urandom_range(0, 5) == 0) ? int'(HALT_W) : int'($urandom_range(0, 63));
      applyStimulus("rand", r, run, stall, jmp, ja, we, pa, pd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
